// File: rtl/temp_display_sequencer_if.sv
// Signal bundle between the temperature sensor controller, the BCD converter
// and the display mux. The slave modport is the sequencer's view of it.
interface temp_display_sequencer_if;
    logic [12:0] temp_in;
    logic        temp_rdy;
    logic        temp_err;
    logic        bcd_idle;
    logic [31:0] bcd_result;
    logic        bcd_trigger;
    logic [31:0] bcd_in;
    logic [31:0] disp_bcd;
    logic [7:0]  disp_dots;
    logic        disp_valid;
    logic        err_flag;

    modport master (
        output temp_in, temp_rdy, temp_err, bcd_idle, bcd_result,
        input  bcd_trigger, bcd_in, disp_bcd, disp_dots, disp_valid, err_flag
    );

    modport slave (
        input  temp_in, temp_rdy, temp_err, bcd_idle, bcd_result,
        output bcd_trigger, bcd_in, disp_bcd, disp_dots, disp_valid, err_flag
    );
endinterface

// File: rtl/temp_display_sequencer.sv
// Samples the sensor word on a fixed tick, averages 2^AVG_LOG2 samples, scales to
// tenths of a degree and sequences one BCD conversion per average for the display.
module temp_display_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 25_000_000,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned MISS_LIMIT    = 4,
    parameter int unsigned CONV_TIMEOUT  = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    temp_display_sequencer_if.slave bus
);

    localparam int unsigned TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned ACC_W  = 12 + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int unsigned TO_W   = $clog2(CONV_TIMEOUT);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(CONV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_AVG   = 3'd1,
        ST_START = 3'd2,
        ST_TRIG  = 3'd3,
        ST_CONV  = 3'd4,
        ST_LATCH = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic               tick_s;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [MISS_W-1:0]  miss_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic               guard_r;
    logic               bcd_trigger_r;
    logic [31:0]        bcd_in_r;
    logic [31:0]        disp_bcd_r;
    logic               disp_valid_r;
    logic [7:0]         disp_dots_r;
    logic               err_flag_r;

    logic [11:0]        sample_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [ACC_W-1:0]   avg_s;
    logic [15:0]        prod_s;
    logic [15:0]        scaled_s;
    logic               take_s;
    logic               miss_inc_s;
    logic               load_bin_s;
    logic               latch_s;
    logic               err_enter_s;
    logic               err_leave_s;
    logic               in_conv_s;

    // Negative readings clamp to zero; scaling to tenths is avg*10/16 in 16 bits.
    assign sample_s  = bus.temp_in[12] ? 12'd0 : bus.temp_in[11:0];
    assign acc_sum_s = acc_r + ACC_W'(sample_s);
    assign avg_s     = acc_r >> AVG_LOG2;
    assign prod_s    = 16'(avg_s) * 16'd10;
    assign scaled_s  = prod_s >> 3'd4;
    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign in_conv_s = (state_r == ST_START) || (state_r == ST_TRIG) || (state_r == ST_CONV);

    // Free-running sample tick counter, independent of the sequencer state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= TICK_W'(0);
        end else begin
            tick_cnt_r <= tick_s ? TICK_W'(0) : tick_cnt_r + TICK_W'(1);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        miss_inc_s   = 1'b0;
        load_bin_s   = 1'b0;
        latch_s      = 1'b0;
        err_enter_s  = 1'b0;
        err_leave_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (!tick_s) begin
                    state_next_s = ST_WAIT;
                end else if (bus.temp_err) begin
                    state_next_s = ST_ERR;
                    err_enter_s  = 1'b1;
                end else if (bus.temp_rdy) begin
                    take_s       = 1'b1;
                    state_next_s = (cnt_r == CNT_LAST) ? ST_AVG : ST_WAIT;
                end else begin
                    miss_inc_s = 1'b1;
                    if (miss_r == MISS_LAST) begin
                        state_next_s = ST_ERR;
                        err_enter_s  = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
            end
            ST_AVG: begin
                load_bin_s   = 1'b1;
                state_next_s = ST_START;
            end
            ST_START: begin
                if (to_cnt_r == TO_LAST) begin
                    state_next_s = ST_ERR;
                    err_enter_s  = 1'b1;
                end else if (bus.bcd_idle) begin
                    state_next_s = ST_TRIG;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_TRIG: begin
                state_next_s = ST_CONV;
            end
            ST_CONV: begin
                // guard_r masks the stale idle level in the cycle right after the trigger
                if (to_cnt_r == TO_LAST) begin
                    state_next_s = ST_ERR;
                    err_enter_s  = 1'b1;
                end else if (bus.bcd_idle && !guard_r) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_CONV;
                end
            end
            ST_LATCH: begin
                latch_s      = 1'b1;
                state_next_s = ST_WAIT;
            end
            ST_ERR: begin
                if (tick_s && bus.temp_rdy && !bus.temp_err) begin
                    take_s       = 1'b1;
                    err_leave_s  = 1'b1;
                    state_next_s = (CNT_LAST == CNT_W'(0)) ? ST_AVG : ST_WAIT;
                end else begin
                    state_next_s = ST_ERR;
                end
            end
            default: begin
                state_next_s = ST_WAIT;
            end
        endcase
    end

    // Accumulator, sample/miss counters and the shared START+CONV timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r    <= ACC_W'(0);
            cnt_r    <= CNT_W'(0);
            miss_r   <= MISS_W'(0);
            to_cnt_r <= TO_W'(0);
            guard_r  <= 1'b0;
        end else begin
            if (err_enter_s || load_bin_s) begin
                acc_r <= ACC_W'(0);
                cnt_r <= CNT_W'(0);
            end else if (take_s) begin
                acc_r <= acc_sum_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (err_enter_s || take_s) begin
                miss_r <= MISS_W'(0);
            end else if (miss_inc_s) begin
                miss_r <= miss_r + MISS_W'(1);
            end
            to_cnt_r <= in_conv_s ? to_cnt_r + TO_W'(1) : TO_W'(0);
            guard_r  <= (state_r == ST_TRIG);
        end
    end

    // Registered converter handshake and display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_trigger_r <= 1'b0;
            bcd_in_r      <= 32'd0;
            disp_bcd_r    <= 32'd0;
            disp_valid_r  <= 1'b0;
            disp_dots_r   <= 8'b0000_0000;
            err_flag_r    <= 1'b0;
        end else begin
            bcd_trigger_r <= (state_next_s == ST_TRIG);
            if (load_bin_s) begin
                bcd_in_r <= {16'd0, scaled_s};
            end
            if (latch_s) begin
                disp_bcd_r   <= bus.bcd_result;
                disp_valid_r <= 1'b1;
            end
            if (err_enter_s) begin
                err_flag_r <= 1'b1;
            end else if (err_leave_s) begin
                err_flag_r <= 1'b0;
            end
            disp_dots_r <= (disp_valid_r && !err_flag_r) ? 8'b0000_0010 : 8'b0000_0000;
        end
    end

    assign bus.bcd_trigger = bcd_trigger_r;
    assign bus.bcd_in      = bcd_in_r;
    assign bus.disp_bcd    = disp_bcd_r;
    assign bus.disp_valid  = disp_valid_r;
    assign bus.disp_dots   = disp_dots_r;
    assign bus.err_flag    = err_flag_r;

endmodule

// File: tb/tb_temp_display_sequencer.sv
// Scoreboard bench: expected converter inputs and display words are queued as
// samples are driven and compared when the sequencer triggers and latches.
module tb_temp_display_sequencer;
    localparam int SP = 16;
    localparam int AL = 2;
    localparam int ML = 4;
    localparam int CT = 256;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    temp_display_sequencer_if bus();

    temp_display_sequencer #(
        .SAMPLE_PERIOD(SP),
        .AVG_LOG2     (AL),
        .MISS_LIMIT   (ML),
        .CONV_TIMEOUT (CT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_vec      = 0;
    int          n_err      = 0;
    int          cyc        = 0;
    int          trig_count = 0;
    int          exp_trigs  = 0;
    int          trig_cyc   = 0;
    int          busy       = 0;
    int          latch_wait = 0;
    int          err_cyc    = 0;
    bit          hang       = 1'b0;
    bit          prev_trig  = 1'b0;
    logic [31:0] pending    = 32'd0;
    logic [31:0] exp_bin[$];
    logic [31:0] exp_disp[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bin2bcd(input int v);
        logic [31:0] r;
        int x;
        r = 32'd0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp(input logic [12:0] s);
        return s[12] ? 0 : int'(s[11:0]);
    endfunction

    function automatic int exp_scaled(input logic [12:0] a, input logic [12:0] b,
                                      input logic [12:0] c, input logic [12:0] d);
        int avg;
        avg = (clamp(a) + clamp(b) + clamp(c) + clamp(d)) >> AL;
        return (avg * 10) >> 4;
    endfunction

    // One clock: converter model plus trigger/latch monitor, evaluated at the negedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (latch_wait > 0) begin
            latch_wait--;
            if (latch_wait == 0) begin
                if (exp_disp.size() == 0) begin
                    check_eq("latch_unexpected", 32'd1, 32'd0);
                end else begin
                    check_eq("disp_bcd_sb", bus.disp_bcd, exp_disp.pop_front());
                    check_eq("disp_valid_sb", 32'(bus.disp_valid), 32'd1);
                end
            end
        end
        if (bus.bcd_trigger) begin
            check_eq("trig_single", 32'(prev_trig), 32'd0);
            trig_count++;
            trig_cyc = cyc;
            if (exp_bin.size() == 0) begin
                check_eq("trig_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("bcd_in", bus.bcd_in, exp_bin.pop_front());
            end
            pending      = bin2bcd(int'(bus.bcd_in));
            busy         = 3;
            bus.bcd_idle = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0 && !hang) begin
                bus.bcd_idle   = 1'b1;
                bus.bcd_result = pending;
                latch_wait     = 2;
            end
        end
        prev_trig = bus.bcd_trigger;
    endtask

    task automatic window(input logic rdy, input logic err, input logic [12:0] val);
        bus.temp_rdy = rdy;
        bus.temp_err = err;
        bus.temp_in  = val;
        repeat (SP) step();
    endtask

    task automatic push_exp(input logic [12:0] a, input logic [12:0] b,
                            input logic [12:0] c, input logic [12:0] d);
        int s;
        s = exp_scaled(a, b, c, d);
        exp_bin.push_back(32'(s));
        if (!hang) exp_disp.push_back(bin2bcd(s));
        exp_trigs++;
    endtask

    task automatic run_avg(input logic [12:0] a, input logic [12:0] b,
                           input logic [12:0] c, input logic [12:0] d);
        push_exp(a, b, c, d);
        window(1'b1, 1'b0, a);
        window(1'b1, 1'b0, b);
        window(1'b1, 1'b0, c);
        window(1'b1, 1'b0, d);
        bus.temp_rdy = 1'b0;
    endtask

    task automatic settle_and_check(input logic [31:0] bcd);
        repeat (12) step();
        check_eq("trig_count", 32'(trig_count), 32'(exp_trigs));
        check_eq("latch_pending", 32'(exp_disp.size()), 32'd0);
        check_eq("disp_bcd", bus.disp_bcd, bcd);
        check_eq("disp_valid", 32'(bus.disp_valid), 32'd1);
        check_eq("disp_dots", 32'(bus.disp_dots), 32'h02);
        check_eq("err_flag_clear", 32'(bus.err_flag), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_trigger"}, 32'(bus.bcd_trigger), 32'd0);
        check_eq({tag, "_bcd_in"}, bus.bcd_in, 32'd0);
        check_eq({tag, "_disp_bcd"}, bus.disp_bcd, 32'd0);
        check_eq({tag, "_disp_valid"}, 32'(bus.disp_valid), 32'd0);
        check_eq({tag, "_disp_dots"}, 32'(bus.disp_dots), 32'd0);
        check_eq({tag, "_err_flag"}, 32'(bus.err_flag), 32'd0);
    endtask

    initial begin
        bus.temp_in    = 13'd0;
        bus.temp_rdy   = 1'b0;
        bus.temp_err   = 1'b0;
        bus.bcd_idle   = 1'b1;
        bus.bcd_result = 32'd0;
        repeat (3) step();
        check_zero_outputs("rst");
        reset_n = 1'b1;

        // steady value, negative clamp, averaging
        run_avg(13'h0190, 13'h0190, 13'h0190, 13'h0190);
        settle_and_check(32'h0000_0250);
        run_avg(13'h1190, 13'h1190, 13'h1190, 13'h1190);
        settle_and_check(32'h0000_0000);
        run_avg(13'h0190, 13'h0190, 13'h01A0, 13'h01A0);
        settle_and_check(32'h0000_0255);

        // sensor error tick, then clean tick clears it and counts as first sample
        push_exp(13'h0190, 13'h0190, 13'h0190, 13'h0190);
        window(1'b0, 1'b1, 13'h0190);
        bus.temp_err = 1'b0;
        step();
        check_eq("err_on_temp_err", 32'(bus.err_flag), 32'd1);
        check_eq("err_dots", 32'(bus.disp_dots), 32'd0);
        check_eq("err_disp_held", bus.disp_bcd, 32'h0000_0255);
        check_eq("err_valid_held", 32'(bus.disp_valid), 32'd1);
        window(1'b1, 1'b0, 13'h0190);
        step();
        check_eq("err_cleared", 32'(bus.err_flag), 32'd0);
        check_eq("dots_restored", 32'(bus.disp_dots), 32'h02);
        window(1'b1, 1'b0, 13'h0190);
        window(1'b1, 1'b0, 13'h0190);
        window(1'b1, 1'b0, 13'h0190);
        bus.temp_rdy = 1'b0;
        settle_and_check(32'h0000_0250);

        // missing samples
        window(1'b0, 1'b0, 13'h0000);
        window(1'b0, 1'b0, 13'h0000);
        check_eq("miss_early", 32'(bus.err_flag), 32'd0);
        window(1'b0, 1'b0, 13'h0000);
        window(1'b0, 1'b0, 13'h0000);
        step();
        check_eq("miss_err", 32'(bus.err_flag), 32'd1);
        check_eq("miss_dots", 32'(bus.disp_dots), 32'd0);
        run_avg(13'h01A0, 13'h01A0, 13'h0190, 13'h0190);
        settle_and_check(32'h0000_0255);

        // converter hang: timeout measured from START (one cycle before the trigger)
        hang = 1'b1;
        run_avg(13'h0190, 13'h0190, 13'h0190, 13'h0190);
        for (int i = 0; i < 400 && !bus.err_flag; i++) step();
        err_cyc = cyc;
        check_eq("hang_err", 32'(bus.err_flag), 32'd1);
        check_eq("hang_trig", 32'(trig_count), 32'(exp_trigs));
        check_eq("timeout_cycles", 32'(err_cyc - trig_cyc), 32'(CT - 1));
        step();
        check_eq("hang_no_latch", bus.disp_bcd, 32'h0000_0255);
        check_eq("hang_dots", 32'(bus.disp_dots), 32'd0);
        hang         = 1'b0;
        busy         = 0;
        bus.bcd_idle = 1'b1;
        run_avg(13'h01A0, 13'h01A0, 13'h01A0, 13'h01A0);
        settle_and_check(32'h0000_0260);

        // reset during a conversion
        hang = 1'b1;
        run_avg(13'h0190, 13'h0190, 13'h0190, 13'h0190);
        for (int i = 0; i < 40 && trig_count != exp_trigs; i++) step();
        check_eq("pre_reset_trig", 32'(trig_count), 32'(exp_trigs));
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        hang           = 1'b0;
        busy           = 0;
        latch_wait     = 0;
        bus.bcd_idle   = 1'b1;
        bus.bcd_result = 32'h0000_9999;
        exp_bin.delete();
        exp_disp.delete();
        repeat (2) step();
        reset_n = 1'b1;
        push_exp(13'h0190, 13'h0190, 13'h0190, 13'h0190);
        window(1'b1, 1'b0, 13'h0190);
        window(1'b1, 1'b0, 13'h0190);
        window(1'b1, 1'b0, 13'h0190);
        check_eq("no_early_trig", 32'(trig_count), 32'(exp_trigs - 1));
        check_eq("stale_not_latched", bus.disp_bcd, 32'd0);
        check_eq("stale_valid", 32'(bus.disp_valid), 32'd0);
        window(1'b1, 1'b0, 13'h0190);
        bus.temp_rdy = 1'b0;
        settle_and_check(32'h0000_0250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
